// File: rtl/mac_pkg.sv
// Shared encodings for the MEM-stage data-memory sequencer.
// Access sizes, FSM states and the alignment rule live here.
package mac_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ST_W,
      RMW_RD,
      RMW_WR,
      DONE
   } state_t;

   // Size 3 is not a legal access and is reported like a misaligned one.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into the old word for read-modify-write.
module byte_lane_unit
   import mac_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      sel_b     = rd_word[{lane, 3'b000} +: 8];
      sel_h     = rd_word[{lane[1], 4'b0000} +: 16];
      load_data = rd_word;
      merged    = wdata;
      case (size)
         SZ_BYTE: begin
            load_data                      = {{24{sign & sel_b[7]}}, sel_b};
            merged                         = rd_word;
            merged[{lane, 3'b000} +: 8]    = wdata[7:0];
         end
         SZ_HALF: begin
            load_data                      = {{16{sign & sel_h[15]}}, sel_h};
            merged                         = rd_word;
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: begin
            load_data = rd_word;
            merged    = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-request load/store sequencer in front of dm's word port;
// sub-word stores are performed as read-modify-write.
module mem_access_ctrl
   import mac_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_sign,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_pc,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic              dm_MemWrite,
   output logic [31:0]       dm_PC,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_writeData,
   input  logic [31:0]       dm_readData
);

   state_t      state;
   logic [1:0]  l_lane;
   logic [1:0]  l_size;
   logic        l_sign;
   logic [31:0] l_wdata;
   logic [31:0] load_data;
   logic [31:0] merged;

   byte_lane_unit u_lane (
      .lane      (l_lane),
      .size      (l_size),
      .sign      (l_sign),
      .rd_word   (dm_readData),
      .wdata     (l_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   assign req_ready = (state == IDLE);

   // Outputs are set on the transition into the state that owns them, so
   // dm_MemWrite/rsp_valid are high exactly during ST_W/RMW_WR and DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         l_lane       <= '0;
         l_size       <= '0;
         l_sign       <= 1'b0;
         l_wdata      <= '0;
         rsp_valid    <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= '0;
         dm_MemWrite  <= 1'b0;
         dm_PC        <= '0;
         dm_addr      <= '0;
         dm_writeData <= '0;
      end else begin
         rsp_valid   <= 1'b0;
         dm_MemWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  l_lane    <= req_addr[1:0];
                  l_size    <= req_size;
                  l_sign    <= req_sign;
                  l_wdata   <= req_wdata;
                  dm_PC     <= req_pc;
                  dm_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  if (misaligned(req_size, req_addr[1:0])) begin
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end else if (!req_write) begin
                     state <= LOAD;
                  end else if (req_size == SZ_WORD) begin
                     dm_writeData <= req_wdata;
                     dm_MemWrite  <= 1'b1;
                     state        <= ST_W;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            LOAD: begin
               rsp_rdata <= load_data;
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            ST_W: begin
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            RMW_RD: begin
               dm_writeData <= merged;
               dm_MemWrite  <= 1'b1;
               state        <= RMW_WR;
            end
            RMW_WR: begin
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               rsp_err <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: a behavioural dm, a reference memory model and a
// scoreboard of expected responses per request.
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        dm_MemWrite;
   logic [31:0] dm_PC;
   logic [31:0] dm_addr;
   logic [31:0] dm_writeData;
   logic [31:0] dm_readData;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int unsigned lat;
      int unsigned writes;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   mem_access_ctrl #(.ADDR_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_sign     (req_sign),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_pc       (req_pc),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .dm_MemWrite  (dm_MemWrite),
      .dm_PC        (dm_PC),
      .dm_addr      (dm_addr),
      .dm_writeData (dm_writeData),
      .dm_readData  (dm_readData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_readData = mem[dm_addr[7:2]];
   always @(posedge clk) if (dm_MemWrite) mem[dm_addr[7:2]] <= dm_writeData;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sg, input logic [1:0] lo);
      logic [31:0] s;
      if (sz == 2'd0) begin
         s = w >> (lo * 8);
         return (sg && s[7]) ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
      end else if (sz == 2'd1) begin
         s = w >> (lo[1] * 16);
         return (sg && s[15]) ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
      end
      return w;
   endfunction

   function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] wd, input logic [1:0] lo);
      logic [31:0] mask;
      if (sz == 2'd2) return wd;
      mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (lo * 8);
      return (w & ~mask) | ((wd << (lo * 8)) & mask);
   endfunction

   task automatic wait_ready();
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
      exp_t        e;
      exp_t        g;
      int unsigned widx;
      int unsigned n;
      int unsigned wr_cnt;
      logic [1:0]  lo;
      bit          busy_ok;
      bit          seen;
      widx    = addr[7:2];
      lo      = addr[1:0];
      n       = 0;
      wr_cnt  = 0;
      busy_ok = 1'b1;
      seen    = 1'b0;
      e.err   = (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
      e.rdata = '0;
      e.writes = 0;
      if (e.err) e.lat = 1;
      else if (!wr) begin
         e.rdata = ld_model(ref_mem[widx], sz, sg, lo);
         e.lat   = 2;
      end else begin
         ref_mem[widx] = st_model(ref_mem[widx], sz, wd, lo);
         e.lat    = (sz == 2'd2) ? 2 : 3;
         e.writes = 1;
      end
      sbq.push_back(e);

      wait_ready();
      req_write = wr;  req_size = sz;  req_sign = sg;
      req_addr  = addr; req_wdata = wd; req_pc = pc;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         if (dm_MemWrite) begin
            wr_cnt++;
            check("wr_addr", dm_addr, {addr[31:2], 2'b00});
            check("wr_pc", dm_PC, pc);
         end
         if (req_ready) busy_ok = 1'b0;
         if (rsp_valid) seen = 1'b1;
      end
      g = sbq.pop_front();
      if (!seen) begin
         check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
         return;
      end
      check("rsp_err", {31'd0, rsp_err}, {31'd0, g.err});
      check("rsp_rdata", rsp_rdata, g.rdata);
      check("latency", n, g.lat);
      check("wr_count", wr_cnt, g.writes);
      check("busy_ready", {31'd0, busy_ok}, 32'd1);
      @(negedge clk);
      check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
      check("ready_back", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
      req_sign = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_memwrite", {31'd0, dm_MemWrite}, 32'd0);
      check("rst_dm_addr", dm_addr, 32'd0);
      check("rst_dm_pc", dm_PC, 32'd0);
      check("rst_wdata", dm_writeData, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h1122_3344, 32'h3000);
      do_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'h3004);
      do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 32'h3008);
      do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h0000_00FF, 32'h300C);
      do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_0080, 32'h3010);
      do_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, 32'h3014);
      do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 32'h3018);
      do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_BEEF, 32'h301C);
      do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h3020);
      do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 32'h3024);
      do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h3028);
      do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'hDEAD_BEEF, 32'h302C);
      do_req(1'b0, 2'd1, 1'b1, 32'h1, 32'h0, 32'h3030);
      do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h1234_5678, 32'h3034);

      // Reset while a byte store sits in RMW_RD.
      do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hA5A5_A5A5, 32'h3038);
      wait_ready();
      req_write = 1'b1; req_size = 2'd0; req_sign = 1'b0;
      req_addr = 32'h8; req_wdata = 32'h0000_003C; req_pc = 32'h303C;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_memwrite", {31'd0, dm_MemWrite}, 32'd0);
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_dm_addr", dm_addr, 32'd0);
      check("mid_rst_dm_pc", dm_PC, 32'd0);
      check("mid_rst_wdata", dm_writeData, 32'd0);
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_dm_word", mem[2], ref_mem[2]);
      reset = 1'b0;
      @(negedge clk);
      do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h3040);
      do_req(1'b1, 2'd0, 1'b0, 32'h8, 32'h0000_003C, 32'h3044);
      do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h3048);

      for (int i = 0; i < 40; i++) begin
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), $urandom, $urandom);
      end

      for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
